// File: rtl/peak_window.sv
// Windowed per-channel peak detector for a packed 12-bit ADC pair.
// Reports {max_x, max_y} once per WIN_LEN accepted samples, then waits for the frame to be sent.
module peak_window #(
  parameter int unsigned WIN_LEN = 256,
  parameter logic [11:0] THRESH  = 12'd200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        smp_valid,
  input  logic [23:0] smp_data,
  input  logic        tx_done,
  output logic [23:0] res_data,
  output logic [1:0]  res_code,
  output logic        busy
);

  localparam int unsigned CNT_W  = 13;
  localparam int unsigned DATA_W = 12;
  localparam int unsigned RES_W  = 2 * DATA_W;

  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(WIN_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [1:0]       CODE_NONE = 2'b00;
  localparam logic [1:0]       CODE_MISS = 2'b01;
  localparam logic [1:0]       CODE_HIT  = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    REPORT  = 2'd2,
    WAIT_TX = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   max_x_q, max_x_d;
  logic [DATA_W-1:0]   max_y_q, max_y_d;
  logic [RES_W-1:0]    res_data_q, res_data_d;
  logic [1:0]          res_code_q, res_code_d;
  logic                busy_q, busy_d;

  logic [DATA_W-1:0]   smp_x, smp_y;
  logic [DATA_W-1:0]   peak_x, peak_y;
  logic [CNT_W-1:0]    cnt_inc;
  logic                win_last;
  logic                above_thresh;

  assign smp_x = smp_data[RES_W-1:DATA_W];
  assign smp_y = smp_data[DATA_W-1:0];

  // Running maxima including the current sample; strict compare keeps the older value on ties.
  always_comb begin
    peak_x       = (smp_x > max_x_q) ? smp_x : max_x_q;
    peak_y       = (smp_y > max_y_q) ? smp_y : max_y_q;
    cnt_inc      = cnt_q + CNT_ONE;
    win_last     = (cnt_inc == LAST_CNT);
    above_thresh = (peak_x >= THRESH) || (peak_y >= THRESH);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    max_x_d    = max_x_q;
    max_y_d    = max_y_q;
    res_data_d = res_data_q;
    res_code_d = CODE_NONE;

    case (state_q)
      IDLE: begin
        if (smp_valid) begin
          max_x_d = smp_x;
          max_y_d = smp_y;
          cnt_d   = CNT_ONE;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (smp_valid) begin
          max_x_d = peak_x;
          max_y_d = peak_y;
          cnt_d   = cnt_inc;
          if (win_last) begin
            // Result is registered here so the pulse coincides with the REPORT cycle.
            state_d    = REPORT;
            res_data_d = {peak_x, peak_y};
            res_code_d = above_thresh ? CODE_HIT : CODE_MISS;
          end
        end
      end
      REPORT: begin
        if (tx_done) begin
          cnt_d   = '0;
          max_x_d = '0;
          max_y_d = '0;
          state_d = IDLE;
        end else begin
          state_d = WAIT_TX;
        end
      end
      WAIT_TX: begin
        if (tx_done) begin
          cnt_d   = '0;
          max_x_d = '0;
          max_y_d = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == REPORT) || (state_d == WAIT_TX);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      max_x_q    <= '0;
      max_y_q    <= '0;
      res_data_q <= '0;
      res_code_q <= CODE_NONE;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      max_x_q    <= max_x_d;
      max_y_q    <= max_y_d;
      res_data_q <= res_data_d;
      res_code_q <= res_code_d;
      busy_q     <= busy_d;
    end
  end

  assign res_data = res_data_q;
  assign res_code = res_code_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_peak_window.sv
// Scoreboard bench for peak_window (WIN_LEN=4, THRESH=200): expected reports are queued
// when a window's last sample is driven and retired when the res_code pulse appears.
module tb_peak_window;

  logic        clk;
  logic        rst;
  logic        smp_valid;
  logic [23:0] smp_data;
  logic        tx_done;
  logic [23:0] res_data;
  logic [1:0]  res_code;
  logic        busy;

  peak_window #(.WIN_LEN(4), .THRESH(12'd200)) dut (
    .clk      (clk),
    .rst      (rst),
    .smp_valid(smp_valid),
    .smp_data (smp_data),
    .tx_done  (tx_done),
    .res_data (res_data),
    .res_code (res_code),
    .busy     (busy)
  );

  typedef struct {
    logic [1:0]  code;
    logic [23:0] data;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  int          vectors;
  int          miscompares;
  int          cyc;
  logic [23:0] last_data;
  logic [11:0] wx[4];
  logic [11:0] wy[4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Retire or reject any res_code pulse visible this cycle.
  task automatic check_out();
    exp_t e;
    if (res_code !== 2'b00) begin
      if (exp_q.size() == 0) begin
        chk("spurious_pulse", 32'(res_code), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("res_code", 32'(res_code), 32'(e.code));
        chk("res_data", 32'(res_data), 32'(e.data));
        chk("latency", 32'(cyc), 32'(e.due));
      end
    end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
      e = exp_q.pop_front();
      chk("pulse_missing", 32'(res_code), 32'(e.code));
    end
  endtask

  // One clock: observe outputs at the falling edge, then drive the next inputs.
  task automatic step(input logic v, input logic [23:0] d, input logic t);
    @(negedge clk);
    cyc++;
    check_out();
    smp_valid = v;
    smp_data  = d;
    tx_done   = t;
  endtask

  task automatic feed_window(input int max_gap);
    logic [11:0] mx;
    logic [11:0] my;
    exp_t        e;
    int          gap;
    mx = 12'd0;
    my = 12'd0;
    for (int i = 0; i < 4; i++) begin
      if (wx[i] > mx) mx = wx[i];
      if (wy[i] > my) my = wy[i];
    end
    for (int i = 0; i < 4; i++) begin
      gap = (max_gap == 0) ? 0 : ((i == 1) ? max_gap : $urandom_range(0, max_gap));
      repeat (gap) step(1'b0, 24'h0, 1'b0);
      step(1'b1, {wx[i], wy[i]}, 1'b0);
    end
    e.code    = (mx >= 12'd200 || my >= 12'd200) ? 2'b11 : 2'b01;
    e.data    = {mx, my};
    e.due     = cyc + 1;
    last_data = e.data;
    exp_q.push_back(e);
  endtask

  // Walk through REPORT and the transmit handshake, optionally with tx_done during REPORT.
  task automatic close_window(input logic early, input int junk);
    step(1'b0, 24'h0, early);
    chk("busy_report", 32'(busy), 32'd1);
    if (early) begin
      step(1'b0, 24'h0, 1'b0);
      chk("busy_after_early_tx", 32'(busy), 32'd0);
    end else begin
      for (int j = 0; j < junk; j++) begin
        step(1'b1, 24'hFFFFFF, 1'b0);
        chk("busy_wait_tx", 32'(busy), 32'd1);
      end
      step(1'b0, 24'h0, 1'b1);
      chk("busy_wait_tx", 32'(busy), 32'd1);
      step(1'b0, 24'h0, 1'b0);
      chk("busy_after_tx", 32'(busy), 32'd0);
    end
    chk("res_data_hold", 32'(res_data), 32'(last_data));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    last_data   = 24'h0;
    rst         = 1'b0;
    smp_valid   = 1'b0;
    smp_data    = 24'h0;
    tx_done     = 1'b0;

    repeat (3) step(1'b0, 24'h0, 1'b0);
    chk("reset_res_data", 32'(res_data), 32'd0);
    chk("reset_res_code", 32'(res_code), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    repeat (2) step(1'b0, 24'h0, 1'b0);
    chk("release_busy", 32'(busy), 32'd0);

    // Peaks land on different samples per channel.
    wx = '{12'd10, 12'd300, 12'd50, 12'd20};
    wy = '{12'd5, 12'd5, 12'd199, 12'd7};
    feed_window(0);
    close_window(1'b0, 0);

    // Threshold boundary: 199 misses, 200 hits.
    wx = '{12'd199, 12'd199, 12'd199, 12'd199};
    wy = wx;
    feed_window(0);
    close_window(1'b0, 0);
    wx = '{12'd200, 12'd200, 12'd200, 12'd200};
    wy = wx;
    feed_window(0);
    close_window(1'b0, 0);

    // Gapped window; samples offered while waiting for tx_done must be dropped.
    wx = '{12'd7, 12'd90, 12'd33, 12'd12};
    wy = '{12'd150, 12'd3, 12'd149, 12'd201};
    feed_window(5);
    close_window(1'b0, 3);
    wx = '{12'd1, 12'd2, 12'd3, 12'd4};
    wy = '{12'd8, 12'd6, 12'd4, 12'd2};
    feed_window(0);
    close_window(1'b0, 0);

    // tx_done during REPORT skips WAIT_TX.
    wx = '{12'd400, 12'd5, 12'd5, 12'd5};
    wy = '{12'd9, 12'd9, 12'd9, 12'd9};
    feed_window(0);
    close_window(1'b1, 0);

    // Reset after two samples discards the partial window.
    step(1'b1, 24'hFFFFFF, 1'b0);
    step(1'b1, 24'hFFFFFF, 1'b0);
    step(1'b0, 24'h0, 1'b0);
    rst = 1'b0;
    step(1'b0, 24'h0, 1'b0);
    chk("midreset_res_data", 32'(res_data), 32'd0);
    chk("midreset_res_code", 32'(res_code), 32'd0);
    chk("midreset_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    repeat (2) step(1'b0, 24'h0, 1'b0);
    chk("postreset_res_data", 32'(res_data), 32'd0);
    wx = '{12'd1, 12'd2, 12'd3, 12'd4};
    wy = '{12'd4, 12'd3, 12'd2, 12'd1};
    feed_window(0);
    close_window(1'b0, 0);

    // Full-scale samples on both channels.
    wx = '{12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF};
    wy = wx;
    feed_window(0);
    step(1'b0, 24'h0, 1'b0);
    chk("fullscale_no_x", 32'($isunknown({res_data, res_code, busy})), 32'd0);
    step(1'b0, 24'h0, 1'b1);
    step(1'b0, 24'h0, 1'b0);
    chk("fullscale_hold", 32'(res_data), 32'hFFFFFF);

    repeat (4) step(1'b0, 24'h0, 1'b0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/peak_window.md
PEAK_WINDOW -- requirements
Module: peak_window

Interface
REQ-001 The parameter list SHALL be: WIN_LEN, default 256, number of accepted samples per window (range 2..4096).
REQ-002 The parameter list SHALL also include: THRESH, default 12'd200, per-channel detection threshold (unsigned).
REQ-003 Port clk SHALL be an input, 1 bit wide: the system clock; all logic is on the rising edge.
REQ-004 Port rst SHALL be an input, 1 bit wide: asynchronous, active-low reset.
REQ-005 Port smp_valid SHALL be an input, 1 bit wide: smp_data is valid this cycle.
REQ-006 Port smp_data SHALL be an input, 24 bits wide: packed ADC pair {x[23:12], y[11:0]}, each channel unsigned.
REQ-007 Port tx_done SHALL be an input, 1 bit wide: one-cycle pulse from the downstream serial stage meaning the frame has been sent.
REQ-008 Port res_data SHALL be an output, 24 bits wide: {max_x, max_y} of the last closed window.
REQ-009 Port res_code SHALL be an output, 2 bits wide: 2'b00 none, 2'b11 signal present, 2'b01 no signal; 2'b10 is never driven.
REQ-010 Port busy SHALL be an output, 1 bit wide: high while the block ignores samples (states REPORT, WAIT_TX).

Function
REQ-011 The FSM SHALL have exactly four states: IDLE, ACCUM, REPORT, WAIT_TX.
REQ-012 IDLE: on the first smp_valid, the block SHALL load max_x = smp_data[23:12], max_y = smp_data[11:0], set cnt = 1 and go to ACCUM.
REQ-013 ACCUM: on each smp_valid, the block SHALL replace max_x only when x > max_x (strict), replace max_y only when y > max_y, and increment cnt.
REQ-014 ACCUM: the block SHALL go to REPORT in the cycle after the sample that makes cnt == WIN_LEN; that sample takes part in the maximum.
REQ-015 The window SHALL count accepted samples only; cycles with smp_valid low do not advance cnt.
REQ-016 REPORT (one cycle): res_data SHALL be {max_x, max_y}; res_code = 2'b11 if max_x >= THRESH or max_y >= THRESH, else 2'b01.
REQ-017 res_code SHALL be non-zero for exactly one clock per window (REPORT only) and 2'b00 in every other cycle.
REQ-018 res_data SHALL hold its value from REPORT until the next REPORT.
REQ-019 After REPORT the block SHALL go to WAIT_TX; on tx_done it SHALL clear cnt, max_x and max_y to 0 and go to IDLE.
REQ-020 A tx_done pulse present during REPORT SHALL be honoured: next state IDLE and WAIT_TX skipped.
REQ-021 tx_done in IDLE or ACCUM SHALL be ignored.
REQ-022 smp_valid in REPORT or WAIT_TX SHALL be dropped, with no effect on state, cnt, max_x or max_y.
REQ-023 busy SHALL be high in REPORT and WAIT_TX and low in IDLE and ACCUM.
REQ-024 Latency SHALL be 1 clock from the last window sample (smp_valid high) to the res_code pulse.
REQ-025 cnt SHALL be 13 bits wide and SHALL NOT wrap, because REQ-014 bounds it to WIN_LEN.
REQ-026 Comparisons SHALL be unsigned 12-bit, with no saturation or scaling applied.

Reset
REQ-027 While rst = 0 the block SHALL asynchronously force state = IDLE, cnt = 0, max_x = 0, max_y = 0, res_data = 24'h0, res_code = 2'b00 and busy = 0.
REQ-028 Reset asserted mid-window or in WAIT_TX SHALL discard all partial results; after release, no res_code pulse occurs until a full new window of WIN_LEN samples.
REQ-029 Reset release SHALL take effect on the first rising edge of clk with rst = 1, and no spurious res_code pulse SHALL occur on release.

Verification (bench uses WIN_LEN=4, THRESH=200)
REQ-030 Scenario 1: feed samples x = 10, 300, 50, 20 and y = 5, 5, 199, 7 back-to-back -> exactly one cycle with res_code = 11 and res_data = {12'd300, 12'd199}, one clock after the 4th sample.
REQ-031 Scenario 2: feed 4 samples with every x and y equal to 199 -> res_code = 01 and res_data = {12'd199, 12'd199}; a following window of all 200 -> res_code = 11.
REQ-032 Scenario 3: interleave the 4 valid samples with idle gaps of 0..5 cycles and inject 3 extra samples during WAIT_TX -> the result uses only the 4 in-window samples, and after tx_done the next window restarts at cnt = 0.
REQ-033 Scenario 4: drive tx_done in the REPORT cycle -> the next state is IDLE, busy drops after one clock, and no WAIT_TX stall occurs.
REQ-034 Scenario 5: pull rst low after 2 samples of a window, then release -> all outputs are 0; 4 new samples are needed before res_code pulses, and the result excludes the pre-reset samples.
REQ-035 Scenario 6: feed the equal maximum 12'hFFF on both channels in all 4 samples -> res_data = 24'hFFFFFF, res_code = 11, and no X/overflow appears on any output.
